// File: rtl/prog_dump_tx_if.sv
// Instruction-RAM read port shared between the program dumper and the RAM.
// The master drives the read strobe and address; read data returns one cycle later.
interface prog_dump_tx_if #(
   parameter int INSTRW = 15
) ();
   logic              memRdEn;
   logic [INSTRW-1:0] memAddr;
   logic [31:0]       memData;

   modport master (
      output memRdEn,
      output memAddr,
      input  memData
   );

   modport slave (
      input  memRdEn,
      input  memAddr,
      output memData
   );
endinterface

// File: rtl/prog_dump_tx.sv
// Program-memory readback transmitter: reads instruction RAM words from address 0
// and sends dumpLen bytes as 8N1 UART frames, low byte of each word first.
module prog_dump_tx #(
   parameter int   MEM_SIZE   = 32767,
   parameter int   BAUD_CYCLE = 868,
   parameter logic LSB_FIRST  = 1'b1,
   localparam int  INSTRW     = $clog2(MEM_SIZE)
) (
   input  logic                 clk,
   input  logic                 rstB,
   input  logic                 start,
   input  logic [INSTRW:0]      dumpLen,
   prog_dump_tx_if.master       mem,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int BW = $clog2(BAUD_CYCLE + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_SEND    = 3'd3;
   localparam logic [2:0] S_FINISH  = 3'd4;

   logic [2:0]        state_reg,  state_next;
   logic [INSTRW:0]   rem_reg,    rem_next;
   logic [INSTRW-1:0] addr_reg,   addr_next;
   logic [31:0]       buffer_reg, buffer_next;
   logic [1:0]        idx_reg,    idx_next;
   logic [3:0]        bit_reg,    bit_next;
   logic [BW-1:0]     baud_reg,   baud_next;
   logic              tx_reg,     tx_next;

   logic [7:0]        byte_next;
   logic [2:0]        sel_next;

   // Frame bit 0 is the start bit, 1..8 data, 9 the stop bit.
   always_comb begin
      state_next  = state_reg;
      rem_next    = rem_reg;
      addr_next   = addr_reg;
      buffer_next = buffer_reg;
      idx_next    = idx_reg;
      bit_next    = bit_reg;
      baud_next   = baud_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               rem_next  = dumpLen;
               addr_next = '0;
               if (dumpLen == '0) state_next = S_FINISH;
               else               state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            state_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            buffer_next = mem.memData;
            idx_next    = 2'd0;
            bit_next    = 4'd0;
            baud_next   = '0;
            state_next  = S_SEND;
         end
         S_SEND: begin
            if (baud_reg == BW'(BAUD_CYCLE - 1)) begin
               baud_next = '0;
               if (bit_reg == 4'd9) begin
                  rem_next = rem_reg - (INSTRW+1)'(1);
                  bit_next = 4'd0;
                  if (rem_reg == (INSTRW+1)'(1)) begin
                     state_next = S_FINISH;
                  end else if (idx_reg == 2'd3) begin
                     addr_next  = addr_reg + INSTRW'(4);
                     state_next = S_FETCH;
                  end else begin
                     idx_next = idx_reg + 2'd1;
                  end
               end else begin
                  bit_next = bit_reg + 4'd1;
               end
            end else begin
               baud_next = baud_reg + BW'(1);
            end
         end
         S_FINISH: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // The line level is registered from the next-state view so tx is glitch-free.
   always_comb begin
      byte_next = buffer_next[{idx_next, 3'b000} +: 8];
      if (LSB_FIRST) sel_next = bit_next[2:0] - 3'd1;
      else           sel_next = 3'd0 - bit_next[2:0];
      if (state_next != S_SEND)  tx_next = 1'b1;
      else if (bit_next == 4'd0) tx_next = 1'b0;
      else if (bit_next == 4'd9) tx_next = 1'b1;
      else                       tx_next = byte_next[sel_next];
   end

   always_ff @(posedge clk or negedge rstB) begin
      if (!rstB) begin
         state_reg  <= S_IDLE;
         rem_reg    <= '0;
         addr_reg   <= '0;
         buffer_reg <= '0;
         idx_reg    <= 2'd0;
         bit_reg    <= 4'd0;
         baud_reg   <= '0;
         tx_reg     <= 1'b1;
      end else begin
         state_reg  <= state_next;
         rem_reg    <= rem_next;
         addr_reg   <= addr_next;
         buffer_reg <= buffer_next;
         idx_reg    <= idx_next;
         bit_reg    <= bit_next;
         baud_reg   <= baud_next;
         tx_reg     <= tx_next;
      end
   end

   assign mem.memRdEn = (state_reg == S_FETCH);
   assign mem.memAddr = addr_reg;
   assign tx          = tx_reg;
   assign busy        = (state_reg == S_FETCH) || (state_reg == S_CAPTURE) || (state_reg == S_SEND);
   assign done        = (state_reg == S_FINISH);

endmodule

// File: tb/tb_prog_dump_tx.sv
// Directed bench for prog_dump_tx with BAUD_CYCLE=4: decodes the UART line from
// recorded samples and checks bytes, frame positions, fetches, done timing and reset.
module tb_prog_dump_tx;
   localparam int MS = 32767;
   localparam int BC = 4;
   localparam int IW = $clog2(MS);

   logic          clk = 1'b0;
   logic          rstB = 1'b0;
   logic          start = 1'b0;
   logic [IW:0]   dumpLen = '0;
   logic          tx1, busy1, done1;
   logic          tx2, busy2, done2;
   logic [31:0]   ram [0:7];

   int checks = 0;
   int errors = 0;

   prog_dump_tx_if #(.INSTRW(IW)) m1 ();
   prog_dump_tx_if #(.INSTRW(IW)) m2 ();

   prog_dump_tx #(.MEM_SIZE(MS), .BAUD_CYCLE(BC), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .rstB(rstB), .start(start), .dumpLen(dumpLen),
      .mem(m1), .tx(tx1), .busy(busy1), .done(done1)
   );

   prog_dump_tx #(.MEM_SIZE(MS), .BAUD_CYCLE(BC), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rstB(rstB), .start(start), .dumpLen(dumpLen),
      .mem(m2), .tx(tx2), .busy(busy2), .done(done2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m1.memRdEn) m1.memData <= ram[m1.memAddr[4:2]];
      if (m2.memRdEn) m2.memData <= ram[m2.memAddr[4:2]];
   end

   // Per-cycle record; entry i holds the values of cycle i+1 after start is sampled.
   logic tx1_q[$], tx2_q[$], busy_q[$], done_q[$];
   int   rd_idx_q[$], rd_addr_q[$];

   always @(posedge clk) begin
      #2;
      if (m1.memRdEn) begin
         rd_idx_q.push_back(tx1_q.size());
         rd_addr_q.push_back(int'(m1.memAddr));
      end
      tx1_q.push_back(tx1);
      tx2_q.push_back(tx2);
      busy_q.push_back(busy1);
      done_q.push_back(done1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic clear_rec();
      tx1_q.delete(); tx2_q.delete(); busy_q.delete(); done_q.delete();
      rd_idx_q.delete(); rd_addr_q.delete();
   endtask

   task automatic launch(input int n);
      @(negedge clk);
      clear_rec();
      dumpLen = (IW+1)'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tg, input int bound);
      logic found;
      found = 1'b0;
      for (int c = 0; c < bound; c++) begin
         if (done1 === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({tg, "_done_seen"}, {31'd0, found}, 32'd1);
      repeat (6) @(negedge clk);
   endtask

   function automatic logic txs(input bit which, input int i);
      return which ? tx2_q[i] : tx1_q[i];
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   // Finds the next start bit at or after 'from'; tord[7] is the first data bit in time.
   task automatic decode(input bit which, input int from, output int pos,
                         output logic [7:0] tord, output logic stop);
      int sz;
      sz = which ? tx2_q.size() : tx1_q.size();
      pos = -1;
      tord = 8'hxx;
      stop = 1'b0;
      for (int i = from; i + 39 < sz; i++) begin
         if (txs(which, i) === 1'b0) begin
            pos = i;
            break;
         end
      end
      if (pos >= 0) begin
         for (int j = 1; j <= 8; j++) tord[8-j] = txs(which, pos + BC*j + 2);
         stop = txs(which, pos + 38);
      end
   endtask

   task automatic verify_dump(input string tg, input int n);
      int nw, pos, p, di, ones, zeros;
      logic [7:0] tord;
      logic stop;
      logic [31:0] word;
      nw = (n + 3) / 4;
      check({tg, "_rd_count"}, rd_idx_q.size(), nw);
      for (int w = 0; w < nw && w < rd_idx_q.size(); w++) begin
         check($sformatf("%s_rd_addr%0d", tg, w), rd_addr_q[w], 4*w);
         check($sformatf("%s_rd_cyc%0d", tg, w), rd_idx_q[w], 162*w);
      end
      p = 0;
      for (int k = 0; k < n; k++) begin
         decode(1'b0, p, pos, tord, stop);
         word = ram[k/4];
         check($sformatf("%s_pos%0d", tg, k), pos, 2 + 40*k + 2*(k/4));
         check($sformatf("%s_byte%0d", tg, k), {24'd0, rev8(tord)}, {24'd0, word[8*(k%4) +: 8]});
         check($sformatf("%s_stop%0d", tg, k), {31'd0, stop}, 32'd1);
         p = pos + 40;
      end
      di = -1;
      ones = 0;
      for (int i = 0; i < done_q.size(); i++) begin
         if (done_q[i] === 1'b1) begin
            if (di < 0) di = i;
            ones++;
         end
      end
      check({tg, "_done_cycle"}, di + 1, 2 + 10*BC*n + 2*(nw - 1) + 1);
      check({tg, "_done_count"}, ones, 1);
      if (di > 0) begin
         check({tg, "_busy_at_done"}, {31'd0, busy_q[di]}, 32'd0);
         check({tg, "_busy_before_done"}, {31'd0, busy_q[di-1]}, 32'd1);
         zeros = 0;
         for (int i = di; i < tx1_q.size(); i++) if (tx1_q[i] !== 1'b1) zeros++;
         check({tg, "_tail_idle"}, zeros, 0);
      end
   endtask

   initial begin
      int pos, zeros, ones, di;
      logic [7:0] tord;
      logic stop;
      logic found;

      for (int i = 0; i < 8; i++) ram[i] = 32'hDEAD_0000 | i;
      ram[0] = 32'h4433_2211;
      ram[1] = 32'h8877_6655;

      // Reset state while rstB is held low and just after release.
      repeat (3) @(negedge clk);
      check("rst_tx", {31'd0, tx1}, 32'd1);
      check("rst_busy", {31'd0, busy1}, 32'd0);
      check("rst_done", {31'd0, done1}, 32'd0);
      check("rst_rden", {31'd0, m1.memRdEn}, 32'd0);
      check("rst_addr", 32'(m1.memAddr), 32'd0);
      rstB = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_tx", {31'd0, tx1}, 32'd1);
      check("idle_busy", {31'd0, busy1}, 32'd0);

      // One full word.
      launch(4);
      wait_done("t1", 400);
      verify_dump("t1", 4);

      // Partial second word: 0x77/0x88 must not appear.
      launch(6);
      wait_done("t2", 600);
      verify_dump("t2", 6);

      // Zero-length dump.
      launch(0);
      wait_done("t3", 20);
      di = -1;
      for (int i = 0; i < done_q.size(); i++) if (done_q[i] === 1'b1 && di < 0) di = i;
      check("t3_done_cycle", di + 1, 1);
      check("t3_rd_count", rd_idx_q.size(), 0);
      zeros = 0;
      for (int i = 0; i < tx1_q.size(); i++) if (tx1_q[i] !== 1'b1) zeros++;
      check("t3_tx_idle", zeros, 0);

      // Second start during byte 2 and a dumpLen change mid-dump are both ignored.
      launch(4);
      found = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (done1 === 1'b1) begin
            found = 1'b1;
            break;
         end
         start = (c == 85);
         if (c == 90) dumpLen = (IW+1)'(2);
         @(negedge clk);
      end
      start = 1'b0;
      check("t4_done_seen", {31'd0, found}, 32'd1);
      repeat (6) @(negedge clk);
      verify_dump("t4", 4);

      // Asynchronous reset in the middle of data bit 1 of byte 0x55 (word 1).
      launch(8);
      repeat (173) @(negedge clk);
      check("t5_pre_tx", {31'd0, tx1}, 32'd0);
      check("t5_pre_addr", 32'(m1.memAddr), 32'd4);
      check("t5_pre_busy", {31'd0, busy1}, 32'd1);
      #2 rstB = 1'b0;
      #1;
      check("t5_rst_tx", {31'd0, tx1}, 32'd1);
      check("t5_rst_busy", {31'd0, busy1}, 32'd0);
      check("t5_rst_rden", {31'd0, m1.memRdEn}, 32'd0);
      check("t5_rst_addr", 32'(m1.memAddr), 32'd0);
      repeat (3) @(negedge clk);
      check("t5_hold_tx", {31'd0, tx1}, 32'd1);
      rstB = 1'b1;
      repeat (2) @(negedge clk);
      check("t5_after_tx", {31'd0, tx1}, 32'd1);
      launch(1);
      wait_done("t5b", 100);
      verify_dump("t5b", 1);

      // MSB-first instance: byte 0x01 appears as 0000_0001 in time order.
      ram[0] = 32'h0000_0001;
      launch(1);
      wait_done("t6", 100);
      decode(1'b1, 0, pos, tord, stop);
      check("t6_msb_pos", pos, 2);
      check("t6_msb_bits", {24'd0, tord}, 32'h01);
      check("t6_msb_stop", {31'd0, stop}, 32'd1);
      ones = 0;
      for (int i = 0; i < done_q.size(); i++) if (done_q[i] === 1'b1) ones++;
      check("t6_done_count", ones, 1);
      decode(1'b0, 0, pos, tord, stop);
      check("t6_lsb_bits", {24'd0, tord}, 32'h80);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
